// File: rtl/neuron_layer_seq_if.sv
// Coefficient-write port and input/output valid-ready streams of neuron_layer_seq.
interface neuron_layer_seq_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 9,
    parameter int W     = 20
);
    localparam int ADDR_W = $clog2(N_OUT * (N_IN + 1));
    localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_data;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN*W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              out_sat;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, out_sat, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, out_sat, busy
    );
endinterface

// File: rtl/neuron_layer_seq.sv
// Time-multiplexed fully-connected layer: one shared multiplier walks every
// (neuron, input) pair, then streams each neuron result over valid/ready.
module neuron_layer_seq #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 9,
    parameter int W     = 20,
    parameter int FRAC  = 15,
    parameter int ACC_W = 48,
    parameter int SAT   = 1
) (
    input logic               clk,
    input logic               rst,
    neuron_layer_seq_if.slave bus
);
    localparam int N_COEF = N_OUT * (N_IN + 1);
    localparam int ADDR_W = $clog2(N_COEF);
    localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int I_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic signed [ACC_W-1:0] C_MAX = (ACC_W'(1) <<< (W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [W-1:0]     r_coef [N_COEF];
    logic signed [W-1:0]     r_x    [N_IN];
    logic signed [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0]        r_o;
    logic [I_W-1:0]          r_i;

    logic                    w_i_last;
    logic                    w_o_last;
    logic                    w_wr_ok;
    logic                    w_in_ready;
    logic                    w_out_valid;
    logic [ADDR_W-1:0]       w_w_sel;
    logic [ADDR_W-1:0]       w_b_sel;
    logic signed [W-1:0]     w_xi;
    logic signed [2*W-1:0]   w_prod;
    logic signed [2*W-1:0]   w_term;
    logic signed [W-1:0]     w_out_data;
    logic                    w_out_sat;

    assign w_i_last = (r_i == I_W'(N_IN - 1));
    assign w_o_last = (r_o == IDX_W'(N_OUT - 1));

    // Writes land only while idle so a vector never sees a mixed coefficient set.
    assign w_wr_ok = bus.wr_en && (r_state == S_IDLE) && (int'(bus.wr_addr) < N_COEF);

    // Select the weight for (o, i), the next neuron's bias and the current x[i].
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        w_w_sel = ADDR_W'(int'(r_o) * (N_IN + 1) + int'(r_i));
        w_b_sel = w_o_last ? ADDR_W'(N_IN) : ADDR_W'((int'(r_o) + 1) * (N_IN + 1) + N_IN);
        w_xi    = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (int'(r_i) == k) w_xi = r_x[k];
        end
    end

    // Full-width signed product; the arithmetic shift floors toward -inf.
    assign w_prod = r_coef[w_w_sel] * w_xi;
    assign w_term = w_prod >>> FRAC;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_MAC;
            end
            S_MAC: begin
                if (w_i_last) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = w_o_last ? S_IDLE : S_MAC;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Coefficient register file.
    always_ff @(posedge clk) begin
        // NOTE: the file is cleared on reset because zeroed coefficients are visible behaviour; this keeps it in flops, not RAM.
        if (rst) begin
            for (int k = 0; k < N_COEF; k++) r_coef[k] <= '0;
        end else if (w_wr_ok) begin
            r_coef[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Operand capture, index counters and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_o   <= '0;
            r_i   <= '0;
            for (int k = 0; k < N_IN; k++) r_x[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < N_IN; k++) r_x[k] <= bus.in_data[k*W +: W];
                        r_o   <= '0;
                        r_i   <= '0;
                        r_acc <= ACC_W'(r_coef[N_IN]);
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_term);
                    r_i   <= w_i_last ? '0 : r_i + I_W'(1);
                end
                S_OUT: begin
                    if (bus.out_ready && !w_o_last) begin
                        r_o   <= r_o + IDX_W'(1);
                        r_i   <= '0;
                        r_acc <= ACC_W'(r_coef[w_b_sel]);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result formatting: clip to W bits when SAT is set, otherwise wrap.
    always_comb begin
        w_out_data = r_acc[W-1:0];
        w_out_sat  = 1'b0;
        if (SAT != 0) begin
            if (r_acc > C_MAX) begin
                w_out_data = C_MAX[W-1:0];
                w_out_sat  = 1'b1;
            end else if (r_acc < C_MIN) begin
                w_out_data = C_MIN[W-1:0];
                w_out_sat  = 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_idx   = r_o;
    assign bus.out_last  = w_out_valid && w_o_last;
    assign bus.out_sat   = w_out_sat;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_neuron_layer_seq.sv
// Self-checking bench for neuron_layer_seq: uniform-coefficient vector table,
// legacy equivalence, latency, backpressure, write gating, mid-run reset and
// a wrap-mode (SAT=0) instance.
module tb_neuron_layer_seq;
    localparam int N_IN   = 2;
    localparam int N_OUT  = 9;
    localparam int W      = 20;
    localparam int FRAC   = 15;
    localparam int ACC_W  = 48;
    localparam int N_COEF = N_OUT * (N_IN + 1);
    localparam int ADDR_W = $clog2(N_COEF);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W)) bus ();
    neuron_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W), .FRAC(FRAC), .ACC_W(ACC_W), .SAT(1))
        u_dut (.clk(clk), .rst(rst), .bus(bus));

    neuron_layer_seq_if #(.N_IN(1), .N_OUT(1), .W(W)) bus_w ();
    neuron_layer_seq #(.N_IN(1), .N_OUT(1), .W(W), .FRAC(FRAC), .ACC_W(ACC_W), .SAT(0))
        u_dut_wrap (.clk(clk), .rst(rst), .bus(bus_w));

    typedef struct {
        logic signed [W-1:0] data;
        int                  idx;
        logic                last;
        logic                sat;
    } exp_t;

    typedef struct {
        int   w0;
        int   w1;
        int   b;
        int   x0;
        int   x1;
        int   z;
        logic sat;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input int val);
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_W'(addr);
        bus.wr_data = W'(val);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic load_uniform(input int w0, input int w1, input int b);
        for (int o = 0; o < N_OUT; o++) begin
            write_coef(o * (N_IN + 1) + 0, w0);
            write_coef(o * (N_IN + 1) + 1, w1);
            write_coef(o * (N_IN + 1) + 2, b);
        end
    endtask

    task automatic load_legacy();
        for (int o = 0; o < N_OUT; o++) begin
            write_coef(o * (N_IN + 1) + 0, 32768);
            write_coef(o * (N_IN + 1) + 1, 16384);
            write_coef(o * (N_IN + 1) + 2, o * 32768);
        end
    endtask

    task automatic push_exp(input int o, input int z, input logic sat);
        exp_t e;
        e.data = W'(z);
        e.idx  = o;
        e.last = (o == N_OUT - 1);
        e.sat  = sat;
        q.push_back(e);
    endtask

    // Legacy coefficients with x = (2.0, -1.0): z[o] = 1.5 + o.
    task automatic push_legacy(input int b0_extra);
        for (int o = 0; o < N_OUT; o++) push_exp(o, 49152 + o * 32768 + ((o == 0) ? b0_extra : 0), 1'b0);
    endtask

    task automatic send(input int x0, input int x1);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.in_data  = {W'(x1), W'(x0)};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || bus.busy !== 1'b0) && n < 400) begin
            tick();
            n++;
        end
        check({name, "_pending"}, q.size(), 0);
    endtask

    // Output monitor: pops the scoreboard on each accepted result and checks
    // that a stalled result holds steady.
    exp_t         e_mon;
    logic         p_stall = 1'b0;
    logic [W-1:0] p_data;
    logic [3:0]   p_idx;
    logic         p_last;
    logic         p_sat;

    always @(negedge clk) begin
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, p_data);
                check("hold_idx", bus.out_idx, p_idx);
                check("hold_last", bus.out_last, p_last);
                check("hold_sat", bus.out_sat, p_sat);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: idx %0d data %0d, want no output", bus.out_idx, $signed(bus.out_data));
                end else begin
                    e_mon = q.pop_front();
                    check("out_data", $signed(bus.out_data), e_mon.data);
                    check("out_idx", bus.out_idx, e_mon.idx);
                    check("out_last", bus.out_last, e_mon.last);
                    check("out_sat", bus.out_sat, e_mon.sat);
                end
            end
            p_stall = bus.out_valid && !bus.out_ready;
            p_data  = bus.out_data;
            p_idx   = bus.out_idx;
            p_last  = bus.out_last;
            p_sat   = bus.out_sat;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[9];
        int   lat;
        int   first_lat;
        int   last_lat;
        int   n;
        int   wrap_exp;

        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus_w.wr_en     = 1'b0;
        bus_w.wr_addr   = '0;
        bus_w.wr_data   = '0;
        bus_w.in_valid  = 1'b0;
        bus_w.in_data   = '0;
        bus_w.out_ready = 1'b1;

        //          w0       w1      b     x0       x1    z        sat
        tbl[0] = '{-1,      0,      0,    1,       0,    -1,      1'b0}; // floor rounding
        tbl[1] = '{-1,      0,      0,    -1,      0,    0,       1'b0};
        tbl[2] = '{524287,  0,      0,    524287,  0,    524287,  1'b1}; // clip high
        tbl[3] = '{524287,  0,      0,    -524288, 0,    -524288, 1'b1}; // clip low
        tbl[4] = '{32768,   -16384, 100,  1000,    2000, 100,     1'b0};
        tbl[5] = '{3,       -3,     7,    5,       5,    6,       1'b0};
        tbl[6] = '{32768,   0,      0,    524287,  0,    524287,  1'b0}; // exactly max
        tbl[7] = '{32768,   0,      -1,   -524288, 0,    -524288, 1'b1}; // bias pushes below min
        tbl[8] = '{0,       0,      -5,   123,     456,  -5,      1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_sat", bus.out_sat, 0);
        check("rst_busy", bus.busy, 0);
        tick();

        for (int v = 0; v < 9; v++) begin
            load_uniform(tbl[v].w0, tbl[v].w1, tbl[v].b);
            for (int o = 0; o < N_OUT; o++) push_exp(o, tbl[v].z, tbl[v].sat);
            send(tbl[v].x0, tbl[v].x1);
            drain($sformatf("vec%0d", v));
        end

        // Legacy equivalence plus first/last latency and in_ready release.
        load_legacy();
        push_legacy(0);
        send(65536, -32768);
        first_lat = -1;
        last_lat  = -1;
        lat       = 1;
        while (lat < 60 && last_lat < 0) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_idx == 0 && first_lat < 0) first_lat = lat;
            if (bus.out_valid && bus.out_idx == N_OUT - 1) begin
                last_lat = lat;
                check("in_ready_at_last", bus.in_ready, 0);
            end
            if (last_lat < 0) begin
                @(posedge clk);
                lat++;
            end
        end
        check("first_latency", first_lat, N_IN + 1);
        check("last_latency", last_lat, N_OUT * (N_IN + 1));
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_last", bus.in_ready, 1);
        drain("legacy");

        // Backpressure: stall idx 3 for five cycles.
        push_legacy(0);
        send(65536, -32768);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.out_idx == 2) && n < 100);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        check("bp_first_idx", bus.out_idx, 3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", bus.out_valid, 1);
            check("bp_idx", bus.out_idx, 3);
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain("backpressure");

        // Writes while busy are dropped.
        push_legacy(0);
        send(65536, -32768);
        tick();
        check("busy_during_mac", bus.busy, 1);
        write_coef(2, 1000);
        drain("gate_busy");
        push_legacy(0);
        send(65536, -32768);
        drain("gate_next");

        // Out-of-range addresses are ignored.
        write_coef(N_COEF, 12345);
        write_coef(31, -7);
        push_legacy(0);
        send(65536, -32768);
        drain("gate_oob");

        // Write and handshake in the same idle cycle: b[0] latched old value.
        push_legacy(0);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = ADDR_W'(2);
        bus.wr_data  = W'(777);
        bus.in_data  = {W'(-32768), W'(65536)};
        bus.in_valid = 1'b1;
        tick();
        bus.wr_en    = 1'b0;
        bus.in_valid = 1'b0;
        drain("same_cycle");
        push_legacy(777);
        send(65536, -32768);
        drain("same_cycle_next");
        write_coef(2, 0);

        // Wrap-mode instance: low W bits of the exact sum, never flagged.
        bus_w.wr_en   = 1'b1;
        bus_w.wr_addr = 1'b0;
        bus_w.wr_data = W'(524287);
        tick();
        bus_w.wr_addr = 1'b1;
        bus_w.wr_data = '0;
        tick();
        bus_w.wr_en = 1'b0;
        for (int t = 0; t < 2; t++) begin
            bus_w.in_data  = (t == 0) ? W'(524287) : W'(-524288);
            wrap_exp       = (t == 0) ? 'hFFFE0 : 16;
            bus_w.in_valid = 1'b1;
            tick();
            bus_w.in_valid = 1'b0;
            lat = 1;
            @(negedge clk);
            while (bus_w.out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            check("wrap_latency", lat, 2);
            check("wrap_data", bus_w.out_data, wrap_exp);
            check("wrap_sat", bus_w.out_sat, 0);
            check("wrap_last", bus_w.out_last, 1);
            check("wrap_idx", bus_w.out_idx, 0);
            @(posedge clk);
            #1;
        end

        // Reset during MAC of idx 4 aborts the vector and zeroes coefficients.
        push_legacy(0);
        send(65536, -32768);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.out_ready && bus.out_idx == 3) && n < 100);
        @(posedge clk);
        #1;
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_idx", bus.out_idx, 4);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_out_idx", bus.out_idx, 0);
        check("midrst_out_data", bus.out_data, 0);
        repeat (10) tick();
        for (int o = 0; o < N_OUT; o++) push_exp(o, 0, 1'b0);
        send(65536, -32768);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_layer_seq.md
# neuron_layer_seq

Parametrised, time-multiplexed fully-connected layer for the signed fixed-point MLP datapath. It computes z[o] = sum_i (w[o][i]*x[i] >>> FRAC) + b[o] for N_OUT outputs from N_IN inputs using a single shared multiplier. Coefficients live in an internal write-port register file, and results stream out one neuron at a time over a valid/ready handshake. It replaces fixed-size combinational output-layer blocks, adding backpressure, run-time coefficient loading and optional saturation.

## Interface
- N_IN, 2, inputs per vector (≥1)
- N_OUT, 9, neurons (≥1)
- W, 20, data/coefficient width, signed two's complement
- FRAC, 15, fractional bits (Q(W-1-FRAC).FRAC)
- ACC_W, 48, accumulator width; must be ≥ 2W-FRAC+clog2(N_IN+1)
- SAT, 1, 1 = saturate result to W bits; 0 = wrap (keep low W bits)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  coefficient write strobe
- wr_addr  in  clog2(N_OUT*(N_IN+1))  coefficient address: o*(N_IN+1)+i; i=N_IN selects bias b[o]
- wr_data  in  W  coefficient value
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  N_IN*W  packed x; x[0] at bits W-1:0
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  W  z[out_idx]
- out_idx  out  clog2(N_OUT) (min 1)  neuron index of out_data
- out_last  out  1  high with out_valid when out_idx = N_OUT-1
- out_sat  out  1  out_data was clipped (always 0 when SAT=0)
- busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE, MAC, OUT.
- IDLE: in_ready=1. On in_valid&in_ready: capture in_data, set o=0, i=0, acc=sign-extended b[0], then go to MAC.
- MAC: each cycle acc += sext(w[o][i]*x[i] >>> FRAC). The product is full 2W signed, the shift is arithmetic (rounds toward −inf), then i++. After i=N_IN-1, go to OUT.
- OUT: out_valid=1. out_data = clip(acc) when SAT=1, else acc[W-1:0]. Clip range is [−2^(W-1), 2^(W-1)−1]; out_sat=1 iff clipped. On out_valid&out_ready: if o=N_OUT-1, go to IDLE; else o++, i=0, acc=sext(b[o+1]), then go to MAC.
- While out_valid=1 and out_ready=0, the following outputs hold stable: out_data, out_idx, out_sat and out_last.
- Coefficient writes apply only when busy=0. Writes while busy=1 are dropped, so a vector always uses one consistent coefficient set. Writes with wr_addr ≥ N_OUT*(N_IN+1) are ignored. A write and an in handshake in the same IDLE cycle: the write takes effect, and the vector uses the new value only if it is read in a later cycle (bias b[0] latched at handshake uses the old value).
- Reset: state=IDLE; coefficient file, acc, captured x, o and i all go to 0.

## Timing
- Values after the reset edge: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, out_sat=0, busy=0.
- rst asserted mid-operation aborts the vector with no further out_valid. Coefficients are zeroed.
- Input handshake in cycle T: z[0] is valid in cycle T+N_IN+1.
- With out_ready held at 1, each subsequent z[o] appears N_IN+1 cycles after the previous one. z[N_OUT-1] appears at T+N_OUT*(N_IN+1).
- in_ready returns to 1 in the cycle after the final out handshake.
- Minimum vector period: N_OUT*(N_IN+1)+1 cycles.
- in_ready=0 whenever busy=1. No input skid buffering.

## Test plan
- Legacy equivalence (defaults): w[o][0]=32768 (1.0), w[o][1]=16384 (0.5), b[o]=o*32768, x=(65536, −32768). Required: out_data=49152+o*32768 for idx 0..8, out_last only on idx 8, out_sat=0.
- Rounding: w=−1, x=1, b=0, other coefficients 0. Required: product term is −1, out_data=−1.
- Saturation: x[0]=w[0][0]=524287, other coefficients 0. SAT=1 gives out_data=524287, out_sat=1. x[0]=−524288, w=524287 gives out_data=−524288, out_sat=1. SAT=0 gives out_data equal to the low 20 bits of the exact sum, out_sat=0.
- Timing/backpressure: handshake at T gives first out_valid at T+3. Hold out_ready=0 for 5 cycles at idx 3: out_data, out_idx and out_valid stay stable, no index is skipped, in_ready stays 0 until the cycle after idx 8 is accepted.
- Write gating: write b[0]=1000 while busy=1, then run the next vector. Required: old b[0] is used. Out-of-range wr_addr leaves all coefficients unchanged.
- Reset mid-MAC: assert rst during MAC of idx 4. Required: out_valid=0 and in_ready=1 after the reset edge. The next vector returns out_data=0 for all idx.
